interp_weight_loader: RTL and testbench

Configuration sequencer for the 2D linear interpolator. On a start request it programs all 8 10-bit interpolation weights into the weight register slave through the APB master's trigger interface. Each weight takes two byte writes. An optional read-back pass verifies every byte. The block gates the interpolator enable so the datapath never runs on a partially loaded weight set.

---
 rtl/interp_pkg.sv | 34 +++
 rtl/interp_xfer_timer.sv | 39 +++
 rtl/interp_weight_loader.sv | 206 ++++++++++++++++++++
 tb/tb_interp_weight_loader.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/interp_pkg.sv
// Shared definitions for the interpolator weight loader: state encoding,
// weight geometry and the byte-index to expected-byte mapping.
package interp_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_REQ  = 3'd1;
  localparam logic [2:0] ST_WR_WAIT = 3'd2;
  localparam logic [2:0] ST_RD_REQ  = 3'd3;
  localparam logic [2:0] ST_RD_WAIT = 3'd4;
  localparam logic [2:0] ST_CHECK   = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;
  localparam logic [2:0] ST_ERR     = 3'd7;

  localparam int NUM_WEIGHTS      = 8;
  localparam int WEIGHT_WIDTH     = 10;
  localparam int BYTES_PER_WEIGHT = 2;
  localparam int NUM_BYTES        = NUM_WEIGHTS * BYTES_PER_WEIGHT;
  localparam int WVEC_WIDTH       = NUM_WEIGHTS * WEIGHT_WIDTH;

  typedef logic [WVEC_WIDTH-1:0] weight_vec_t;

  // Even bytes carry weight[7:0]; odd bytes carry the two high bits zero-extended.
  function automatic logic [7:0] expected_byte(input weight_vec_t w, input logic [3:0] idx);
    logic [WEIGHT_WIDTH-1:0] wk;
    wk = '0;
    for (int k = 0; k < NUM_WEIGHTS; k++) begin
      if (idx[3:1] == 3'(k)) begin
        wk = w[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
    end
    return idx[0] ? {6'b000000, wk[9:8]} : wk[7:0];
  endfunction

endpackage

// File: rtl/interp_xfer_timer.sv
// Saturating 8-bit wait counter for one APB transfer; flags expiry on the
// cycle whose increment would reach TIMEOUT (TIMEOUT of 0 never expires).
module interp_xfer_timer #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic o_expired
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // next count: clear wins, otherwise count while enabled and not saturated
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (en && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired = (TIMEOUT != 8'd0) && en && (cnt_q == (TIMEOUT - 8'd1));

endmodule

// File: rtl/interp_weight_loader.sv
// Programs the eight interpolator weights over APB byte writes, optionally
// reads them back, and only enables the interpolator after a clean load.
module interp_weight_loader
  import interp_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    SEL_WIDTH  = 4,
  parameter int                    SEL_IDX    = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 10'h000,
  parameter int                    TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_verify,
  input  logic [WVEC_WIDTH-1:0] i_weights,
  input  logic                  i_apb_done,
  input  logic [DATA_WIDTH-1:0] i_apb_rdata,
  output logic [ADDR_WIDTH-1:0] o_apb_addr,
  output logic [DATA_WIDTH-1:0] o_apb_data,
  output logic                  o_apb_write_trg,
  output logic                  o_apb_read_trg,
  output logic [SEL_WIDTH-1:0]  o_apb_sel,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [3:0]            o_err_idx,
  output logic                  o_interp_en
);

  localparam logic [SEL_WIDTH-1:0] SEL_ONEHOT = {{(SEL_WIDTH-1){1'b0}}, 1'b1} << SEL_IDX;

  logic [2:0]            state_q,   state_d;
  logic [3:0]            b_q,       b_d;
  weight_vec_t           w_q,       w_d;
  logic                  verify_q,  verify_d;
  logic [7:0]            rdata_q,   rdata_d;
  logic                  err_q,     err_d;
  logic [3:0]            err_idx_q, err_idx_d;
  logic                  ien_q,     ien_d;
  logic                  busy_q,    busy_d;
  logic                  done_q,    done_d;
  logic                  wr_trg_q,  wr_trg_d;
  logic                  rd_trg_q,  rd_trg_d;
  logic [SEL_WIDTH-1:0]  sel_q,     sel_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic [DATA_WIDTH-1:0] data_q,    data_d;
  logic                  tmr_clr_s, tmr_en_s, tmr_expired_s;

  assign tmr_clr_s = (state_q == ST_WR_REQ)  || (state_q == ST_RD_REQ);
  assign tmr_en_s  = (state_q == ST_WR_WAIT) || (state_q == ST_RD_WAIT);

  interp_xfer_timer #(.TIMEOUT(8'(TIMEOUT))) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (tmr_clr_s),
    .en        (tmr_en_s),
    .o_expired (tmr_expired_s)
  );

  // sequencer next-state; a done pulse takes priority over a same-cycle timeout
  always_comb begin
    state_d   = state_q;
    b_d       = b_q;
    w_d       = w_q;
    verify_d  = verify_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    ien_d     = ien_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (i_start) begin
          state_d   = ST_WR_REQ;
          b_d       = 4'd0;
          w_d       = i_weights;
          verify_d  = i_verify;
          err_d     = 1'b0;
          err_idx_d = 4'd0;
          ien_d     = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_REQ: state_d = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (i_apb_done) begin
          if (b_q == 4'd15) begin
            if (verify_q) begin
              state_d = ST_RD_REQ;
              b_d     = 4'd0;
            end else begin
              state_d = ST_DONE;
              ien_d   = 1'b1;
            end
          end else begin
            b_d     = b_q + 4'd1;
            state_d = ST_WR_REQ;
          end
        end else if (tmr_expired_s) begin
          state_d   = ST_ERR;
          err_d     = 1'b1;
          err_idx_d = b_q;
        end else begin
          state_d = ST_WR_WAIT;
        end
      end
      ST_RD_REQ: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (i_apb_done) begin
          rdata_d = i_apb_rdata[7:0];
          state_d = ST_CHECK;
        end else if (tmr_expired_s) begin
          state_d   = ST_ERR;
          err_d     = 1'b1;
          err_idx_d = b_q;
        end else begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_CHECK: begin
        if (rdata_q != expected_byte(w_q, b_q)) begin
          state_d   = ST_ERR;
          err_d     = 1'b1;
          err_idx_d = b_q;
        end else if (b_q == 4'd15) begin
          state_d = ST_DONE;
          ien_d   = 1'b1;
        end else begin
          b_d     = b_q + 4'd1;
          state_d = ST_RD_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // APB-facing outputs are decoded from the next state so they leave flops
  always_comb begin
    busy_d   = (state_d >= ST_WR_REQ) && (state_d <= ST_CHECK);
    done_d   = (state_d == ST_DONE);
    wr_trg_d = (state_d == ST_WR_REQ);
    rd_trg_d = (state_d == ST_RD_REQ);
    sel_d    = busy_d ? SEL_ONEHOT : {SEL_WIDTH{1'b0}};
    if (wr_trg_d || rd_trg_d) begin
      addr_d = BASE_ADDR + ADDR_WIDTH'(b_d);
    end else begin
      addr_d = addr_q;
    end
    if (wr_trg_d) begin
      data_d = DATA_WIDTH'(expected_byte(w_d, b_d));
    end else begin
      data_d = data_q;
    end
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      b_q       <= 4'd0;
      w_q       <= '0;
      verify_q  <= 1'b0;
      rdata_q   <= 8'd0;
      err_q     <= 1'b0;
      err_idx_q <= 4'd0;
      ien_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_trg_q  <= 1'b0;
      rd_trg_q  <= 1'b0;
      sel_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      b_q       <= b_d;
      w_q       <= w_d;
      verify_q  <= verify_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
      ien_q     <= ien_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_trg_q  <= wr_trg_d;
      rd_trg_q  <= rd_trg_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  assign o_apb_addr      = addr_q;
  assign o_apb_data      = data_q;
  assign o_apb_write_trg = wr_trg_q;
  assign o_apb_read_trg  = rd_trg_q;
  assign o_apb_sel       = sel_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_err           = err_q;
  assign o_err_idx       = err_idx_q;
  assign o_interp_en     = ien_q;

endmodule

// File: tb/tb_interp_weight_loader.sv
// Directed bench for interp_weight_loader with a behavioural APB slave that
// answers each trigger one cycle later, with optional stall and corruption.
module tb_interp_weight_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_start = 1'b0;
  logic        i_verify = 1'b0;
  logic [79:0] i_weights = 80'd0;
  logic        i_apb_done = 1'b0;
  logic [7:0]  i_apb_rdata = 8'd0;
  logic [9:0]  o_apb_addr;
  logic [7:0]  o_apb_data;
  logic        o_apb_write_trg, o_apb_read_trg;
  logic [3:0]  o_apb_sel;
  logic        o_busy, o_done, o_err, o_interp_en;
  logic [3:0]  o_err_idx;

  int total = 0;
  int bad   = 0;

  interp_weight_loader #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_verify(i_verify),
    .i_weights(i_weights), .i_apb_done(i_apb_done), .i_apb_rdata(i_apb_rdata),
    .o_apb_addr(o_apb_addr), .o_apb_data(o_apb_data),
    .o_apb_write_trg(o_apb_write_trg), .o_apb_read_trg(o_apb_read_trg),
    .o_apb_sel(o_apb_sel), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_err_idx(o_err_idx), .o_interp_en(o_interp_en)
  );

  always #5 clk = ~clk;

  localparam logic [79:0] W1 = {10'h200, 10'h0FF, 10'h100, 10'h000,
                                10'h2AA, 10'h155, 10'h3FF, 10'h001};
  localparam logic [79:0] W3 = {8{10'h2C5}};
  logic [7:0] bytes1 [16] = '{8'h01, 8'h00, 8'hFF, 8'h03, 8'h55, 8'h01, 8'hAA, 8'h02,
                              8'h00, 8'h00, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h02};

  // slave model state and transaction logs
  logic [7:0] mem [16];
  logic [9:0] wr_addr_log [64];
  logic [7:0] wr_data_log [64];
  logic [9:0] rd_addr_log [64];
  int   wr_cnt = 0, rd_cnt = 0, done_cnt = 0, viol = 0;
  int   stall_addr = -1, corrupt_addr = -1;
  logic pend = 1'b0, prev_trg = 1'b0;
  logic [7:0] resp = 8'd0;

  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0; prev_trg = 1'b0; i_apb_done = 1'b0;
    end else begin
      i_apb_done  = pend;
      i_apb_rdata = pend ? resp : 8'h00;
      pend = 1'b0;
      if (o_apb_write_trg) begin
        if (wr_cnt < 64) begin
          wr_addr_log[wr_cnt] = o_apb_addr;
          wr_data_log[wr_cnt] = o_apb_data;
        end
        wr_cnt++;
        mem[o_apb_addr[3:0]] = o_apb_data;
        if (int'(o_apb_addr) != stall_addr) pend = 1'b1;
      end
      if (o_apb_read_trg) begin
        if (rd_cnt < 64) rd_addr_log[rd_cnt] = o_apb_addr;
        rd_cnt++;
        resp = (int'(o_apb_addr) == corrupt_addr) ? 8'h00 : mem[o_apb_addr[3:0]];
        pend = 1'b1;
      end
      if (o_apb_write_trg && o_apb_read_trg) viol++;
      if ((o_apb_write_trg || o_apb_read_trg) && prev_trg) viol++;
      prev_trg = o_apb_write_trg || o_apb_read_trg;
      if (o_done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [79:0] w, input logic v);
    wr_cnt = 0; rd_cnt = 0; done_cnt = 0;
    @(negedge clk);
    i_start = 1'b1; i_verify = v; i_weights = w;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_end(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(o_done || o_err) && n < 400);
  endtask

  int n;

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_outs", 32'({o_apb_addr, o_apb_data, o_apb_write_trg, o_apb_read_trg, o_apb_sel}), 32'd0);
    chk("rst_flags", 32'({o_done, o_err, o_err_idx, o_interp_en}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // 1: write-only load, 32 cycles from start to DONE
    do_start(W1, 1'b0);
    chk("t1_busy", 32'(o_busy), 32'd1);
    chk("t1_sel", 32'(o_apb_sel), 32'd1);
    wait_end(n);
    chk("t1_cycles", 32'(n), 32'd32);
    chk("t1_done", 32'({o_done, o_err, o_interp_en, o_busy}), 32'b1010);
    chk("t1_sel_idle", 32'(o_apb_sel), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_done_pulses", 32'(done_cnt), 32'd1);
    chk("t1_wr_cnt", 32'(wr_cnt), 32'd16);
    chk("t1_rd_cnt", 32'(rd_cnt), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t1_addr%0d", i), 32'(wr_addr_log[i]), 32'(i));
      chk($sformatf("t1_data%0d", i), 32'(wr_data_log[i]), 32'(bytes1[i]));
    end
    chk("t1_interp_en_held", 32'(o_interp_en), 32'd1);

    // 2: verify pass with a faithful slave
    do_start(W1, 1'b1);
    chk("t2_ien_cleared", 32'(o_interp_en), 32'd0);
    wait_end(n);
    chk("t2_end", 32'({o_done, o_err, o_interp_en}), 32'b101);
    chk("t2_wr_cnt", 32'(wr_cnt), 32'd16);
    chk("t2_rd_cnt", 32'(rd_cnt), 32'd16);
    chk("t2_rd_addr15", 32'(rd_addr_log[15]), 32'd15);

    // 3: slave corrupts byte 5 on read-back
    corrupt_addr = 5;
    do_start(W1, 1'b1);
    wait_end(n);
    chk("t3_err", 32'({o_done, o_err, o_interp_en, o_busy}), 32'b0100);
    chk("t3_err_idx", 32'(o_err_idx), 32'd5);
    repeat (5) @(posedge clk);
    #1;
    chk("t3_rd_cnt", 32'(rd_cnt), 32'd6);
    chk("t3_last_rd", 32'(rd_addr_log[5]), 32'd5);
    chk("t3_err_sticky", 32'(o_err), 32'd1);
    corrupt_addr = -1;

    // 4: slave never completes byte 3; TIMEOUT is 8
    stall_addr = 3;
    do_start(W1, 1'b0);
    chk("t4_err_cleared", 32'(o_err), 32'd0);
    for (int i = 0; i < 40; i++) begin
      if (o_apb_write_trg && o_apb_addr == 10'd3) break;
      @(posedge clk); #1;
    end
    chk("t4_trg3_seen", 32'({o_apb_write_trg, o_apb_addr}), 32'({1'b1, 10'd3}));
    @(posedge clk);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!o_err && n < 50);
    chk("t4_timeout_cycles", 32'(n), 32'd8);
    chk("t4_state", 32'({o_err, o_busy, o_interp_en, o_done}), 32'b1000);
    chk("t4_err_idx", 32'(o_err_idx), 32'd3);
    chk("t4_wr_cnt", 32'(wr_cnt), 32'd4);
    chk("t4_sel_idle", 32'(o_apb_sel), 32'd0);
    stall_addr = -1;

    // 6: recovery after an error
    do_start(W1, 1'b0);
    chk("t6_err_clear", 32'(o_err), 32'd0);
    chk("t6_err_idx_clear", 32'(o_err_idx), 32'd0);
    wait_end(n);
    chk("t6_end", 32'({o_done, o_err, o_interp_en}), 32'b101);
    chk("t6_cycles", 32'(n), 32'd32);

    // 5: start while busy is ignored, then reset in the read pass
    do_start(W1, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    i_start = 1'b1; i_weights = W3; i_verify = 1'b0;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rd_cnt >= 3) break;
      @(posedge clk); #1;
    end
    chk("t5_in_read", 32'(rd_cnt >= 3), 32'd1);
    chk("t5_wr_cnt", 32'(wr_cnt), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t5_data%0d", i), 32'(wr_data_log[i]), 32'(bytes1[i]));
    end
    chk("t5_no_err", 32'(o_err), 32'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_outs", 32'({o_apb_addr, o_apb_data, o_apb_write_trg, o_apb_read_trg, o_apb_sel}), 32'd0);
    chk("t5_rst_flags", 32'({o_busy, o_done, o_err, o_err_idx, o_interp_en}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    do_start(W3, 1'b0);
    wait_end(n);
    chk("t5_fresh_cycles", 32'(n), 32'd32);
    chk("t5_fresh_end", 32'({o_done, o_err, o_interp_en}), 32'b101);
    chk("t5_fresh_d0", 32'(wr_data_log[0]), 32'h0C5);
    chk("t5_fresh_d1", 32'(wr_data_log[1]), 32'h002);
    chk("t5_fresh_d15", 32'(wr_data_log[15]), 32'h002);

    chk("trigger_rules", 32'(viol), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
